fetch_sequencer: RTL and testbench

Control block for the 16-bit fetch stage. It drives the PC write enable, the PC source select (PC+2 or branch target) and the IF/ID register write/flush controls. It sequences boot hold-off, load-use stalls, taken-branch redirects with bubble insertion, and halt/resume. It sits beside the fetch stage and takes requests from decode/execute hazard logic.

---
 rtl/fetch_seq_pkg.sv | 47 ++++
 rtl/fetch_seq_counter.sv | 25 ++
 rtl/fetch_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared types for the fetch sequencer: state encoding and PC/IF-ID control bundle.
// Optional perf counters in fetch_sequencer are enabled with FETCH_SEQ_PERF_EN.
package fetch_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        STALL = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic pc_src;
        logic if_id_write;
        logic if_id_flush;
    } ctrl_t;

    // Applied while rst is high: PC frozen, IF/ID forced to a NOP.
    localparam ctrl_t CTRL_NOP = '{
        pc_write: 1'b0, pc_src: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1
    };

    localparam ctrl_t CTRL_RUN = '{
        pc_write: 1'b1, pc_src: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b0
    };

    localparam ctrl_t CTRL_REDIRECT = '{
        pc_write: 1'b1, pc_src: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1
    };

    localparam ctrl_t CTRL_BUBBLE = '{
        pc_write: 1'b1, pc_src: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b1
    };

    localparam ctrl_t CTRL_HOLD_NOP = '{
        pc_write: 1'b0, pc_src: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b1
    };

    localparam ctrl_t CTRL_FREEZE = '{
        pc_write: 1'b0, pc_src: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0
    };

endpackage

// File: rtl/fetch_seq_counter.sv
// Saturating up-counter with synchronous clear and parallel load.
module fetch_seq_counter #(
    parameter int unsigned  W   = 4,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && count != MAX) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: boot hold-off, load-use stalls, branch flushes, halt.
// Define FETCH_SEQ_PERF_EN to add the stall_cycles / flush_events counters.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int BOOT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_use_hazard,
    input  logic       branch_taken,
    input  logic       halt_req,
    input  logic       resume,
    output logic       pc_write,
    output logic       pc_src,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       halted,
    output logic       stall_timeout,
`ifdef FETCH_SEQ_PERF_EN
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events,
`endif
    output logic [2:0] ctrl_state
);

    localparam int SW = $clog2(MAX_STALL + 1);
    localparam logic [3:0]    BOOT_LAST  = 4'(BOOT_CYCLES - 1);
    localparam logic [1:0]    FLUSH_LAST = 2'(FLUSH_CYCLES - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(MAX_STALL - 1);
    localparam state_t        REDIR_NEXT = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_t state, state_n;
    ctrl_t  ctrl;

    logic [3:0]    boot_cnt;
    logic [1:0]    flush_cnt;
    logic [SW-1:0] stall_cnt;

    logic boot_inc;
    logic flush_load, flush_inc;
    logic stall_load, stall_inc, stall_clr;
    logic timeout_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_timeout <= 1'b0;
        end else if (timeout_set) begin
            stall_timeout <= 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        boot_inc    = 1'b0;
        flush_load  = 1'b0;
        flush_inc   = 1'b0;
        stall_load  = 1'b0;
        stall_inc   = 1'b0;
        stall_clr   = 1'b0;
        timeout_set = 1'b0;
        unique case (state)
            BOOT: begin
                if (boot_cnt == BOOT_LAST) state_n = RUN;
                else boot_inc = 1'b1;
            end
            RUN: begin
                if (branch_taken) begin
                    flush_load = 1'b1;
                    state_n    = REDIR_NEXT;
                end else if (halt_req) begin
                    state_n = HALT;
                end else if (load_use_hazard) begin
                    stall_load = 1'b1;
                    state_n    = STALL;
                end
            end
            STALL: begin
                if (branch_taken) begin
                    flush_load = 1'b1;
                    stall_clr  = 1'b1;
                    state_n    = REDIR_NEXT;
                end else if (!load_use_hazard) begin
                    stall_clr = 1'b1;
                    state_n   = RUN;
                end else if (stall_cnt == STALL_LAST) begin
                    // This cycle is the MAX_STALL-th frozen one: fire the watchdog.
                    timeout_set = 1'b1;
                    stall_clr   = 1'b1;
                    state_n     = RUN;
                end else begin
                    stall_inc = 1'b1;
                end
            end
            FLUSH: begin
                if (branch_taken) flush_load = 1'b1;
                else if (flush_cnt == FLUSH_LAST) state_n = RUN;
                else flush_inc = 1'b1;
            end
            HALT: begin
                if (resume) state_n = RUN;
            end
            default: state_n = BOOT;
        endcase
    end

    always_comb begin
        ctrl   = CTRL_NOP;
        halted = 1'b0;
        if (!rst) begin
            unique case (state)
                BOOT: ctrl = CTRL_HOLD_NOP;
                RUN, STALL: begin
                    if (branch_taken) ctrl = CTRL_REDIRECT;
                    else if (state == RUN && halt_req) ctrl = CTRL_HOLD_NOP;
                    else if (load_use_hazard) ctrl = CTRL_FREEZE;
                    else ctrl = CTRL_RUN;
                end
                FLUSH: ctrl = branch_taken ? CTRL_REDIRECT : CTRL_BUBBLE;
                HALT: begin
                    ctrl   = CTRL_FREEZE;
                    halted = 1'b1;
                end
                default: ctrl = CTRL_NOP;
            endcase
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign pc_src      = ctrl.pc_src;
    assign if_id_write = ctrl.if_id_write;
    assign if_id_flush = ctrl.if_id_flush;
    assign ctrl_state  = state;

    fetch_seq_counter #(.W(4)) u_boot_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (1'b0),
        .load     (1'b0),
        .load_val (4'd0),
        .inc      (boot_inc),
        .count    (boot_cnt)
    );

    fetch_seq_counter #(.W(2)) u_flush_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (1'b0),
        .load     (flush_load),
        .load_val (2'd1),
        .inc      (flush_inc),
        .count    (flush_cnt)
    );

    fetch_seq_counter #(.W(SW), .MAX(SW'(MAX_STALL))) u_stall_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (stall_clr),
        .load     (stall_load),
        .load_val (SW'(1)),
        .inc      (stall_inc),
        .count    (stall_cnt)
    );

`ifdef FETCH_SEQ_PERF_EN
    fetch_seq_counter #(.W(16)) u_stall_perf (
        .clk      (clk),
        .rst      (rst),
        .clr      (1'b0),
        .load     (1'b0),
        .load_val (16'd0),
        .inc      (state == STALL && !ctrl.pc_write),
        .count    (stall_cycles)
    );

    fetch_seq_counter #(.W(16)) u_flush_perf (
        .clk      (clk),
        .rst      (rst),
        .clr      (1'b0),
        .load     (1'b0),
        .load_val (16'd0),
        .inc      (ctrl.pc_src),
        .count    (flush_events)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer against a cycle-level behavioural model.
module tb_fetch_sequencer;

    localparam int BOOT_CYCLES  = 2;
    localparam int FLUSH_CYCLES = 3;
    localparam int MAX_STALL    = 15;

    localparam int S_BOOT  = 0;
    localparam int S_RUN   = 1;
    localparam int S_STALL = 2;
    localparam int S_FLUSH = 3;
    localparam int S_HALT  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_use_hazard = 1'b0;
    logic branch_taken = 1'b0;
    logic halt_req = 1'b0;
    logic resume = 1'b0;
    logic pc_write, pc_src, if_id_write, if_id_flush;
    logic halted, stall_timeout;
    logic [2:0] ctrl_state;
`ifdef FETCH_SEQ_PERF_EN
    logic [15:0] stall_cycles, flush_events;
`endif

    fetch_sequencer #(
        .BOOT_CYCLES  (BOOT_CYCLES),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MAX_STALL    (MAX_STALL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .load_use_hazard (load_use_hazard),
        .branch_taken    (branch_taken),
        .halt_req        (halt_req),
        .resume          (resume),
        .pc_write        (pc_write),
        .pc_src          (pc_src),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .halted          (halted),
        .stall_timeout   (stall_timeout),
`ifdef FETCH_SEQ_PERF_EN
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events),
`endif
        .ctrl_state      (ctrl_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [8:0] v;
        logic [31:0] p;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Behavioural model: remaining/elapsed cycle counts per phase.
    bit m_valid = 0;
    int m_state = S_BOOT;
    int boot_left, flush_left, stall_len;
    bit m_to;
    int m_stall_cyc, m_flush_ev;

    function automatic int sat16(input int x);
        return (x >= 65535) ? 65535 : x + 1;
    endfunction

    task automatic redirect();
        m_flush_ev = sat16(m_flush_ev);
        stall_len  = 0;
        if (FLUSH_CYCLES > 1) begin
            m_state    = S_FLUSH;
            flush_left = FLUSH_CYCLES - 1;
        end else begin
            m_state = S_RUN;
        end
    endtask

    task automatic step(input bit r, input bit lu, input bit br,
                        input bit hr, input bit rs, input string tag);
        exp_t e;
        bit [3:0] c;
        bit h;
        int cur_st;
        bit cur_to;
        int cur_sc, cur_fe;
        @(negedge clk);
        rst = r;
        load_use_hazard = lu;
        branch_taken = br;
        halt_req = hr;
        resume = rs;
        cur_st = m_state;
        cur_to = m_to;
        cur_sc = m_stall_cyc;
        cur_fe = m_flush_ev;
        h = 1'b0;
        c = 4'b0001;
        if (r) begin
            m_state = S_BOOT;
            boot_left = BOOT_CYCLES;
            flush_left = 0;
            stall_len = 0;
            m_to = 0;
            m_stall_cyc = 0;
            m_flush_ev = 0;
        end else begin
            case (m_state)
                S_BOOT: begin
                    c = 4'b0011;
                    boot_left--;
                    if (boot_left == 0) m_state = S_RUN;
                end
                S_RUN: begin
                    if (br) begin
                        c = 4'b1111;
                        redirect();
                    end else if (hr) begin
                        c = 4'b0011;
                        m_state = S_HALT;
                    end else if (lu) begin
                        c = 4'b0000;
                        m_state = S_STALL;
                        stall_len = 1;
                    end else begin
                        c = 4'b1010;
                    end
                end
                S_STALL: begin
                    if (br) begin
                        c = 4'b1111;
                        redirect();
                    end else if (!lu) begin
                        c = 4'b1010;
                        m_state = S_RUN;
                        stall_len = 0;
                    end else begin
                        c = 4'b0000;
                        m_stall_cyc = sat16(m_stall_cyc);
                        stall_len++;
                        if (stall_len >= MAX_STALL) begin
                            m_to = 1;
                            stall_len = 0;
                            m_state = S_RUN;
                        end
                    end
                end
                S_FLUSH: begin
                    if (br) begin
                        c = 4'b1111;
                        m_flush_ev = sat16(m_flush_ev);
                        flush_left = FLUSH_CYCLES - 1;
                    end else begin
                        c = 4'b1011;
                        flush_left--;
                        if (flush_left == 0) m_state = S_RUN;
                    end
                end
                default: begin
                    c = 4'b0000;
                    h = 1'b1;
                    if (rs) m_state = S_RUN;
                end
            endcase
        end
        if (m_valid) begin
            e.tag = tag;
            e.v = {c, h, cur_to, 3'(cur_st)};
            e.p = {16'(cur_sc), 16'(cur_fe)};
            exp_q.push_back(e);
        end
        if (r) m_valid = 1;
    endtask

    initial begin : monitor
        exp_t e;
        logic [8:0] got;
        forever begin
            @(negedge clk);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {pc_write, pc_src, if_id_write, if_id_flush,
                       halted, stall_timeout, ctrl_state};
                checks++;
                if (got !== e.v) begin
                    errors++;
                    $display("FAIL %s: got %b want %b (pw ps iw fl h to st)",
                             e.tag, got, e.v);
                end
`ifdef FETCH_SEQ_PERF_EN
                checks++;
                if ({stall_cycles, flush_events} !== e.p) begin
                    errors++;
                    $display("FAIL %s perf: got %h want %h", e.tag,
                             {stall_cycles, flush_events}, e.p);
                end
`endif
            end
        end
    end

    initial begin : stim
        bit lu_lvl;
        step(1, 0, 0, 0, 0, "rst0");
        step(1, 0, 0, 0, 0, "rst1");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, "boot");
        // branch and hazard together: redirect wins, hazard ignored in FLUSH
        step(0, 1, 1, 0, 0, "br_lu");
        step(0, 1, 0, 1, 0, "flush1");
        step(0, 1, 0, 1, 0, "flush2");
        step(0, 0, 0, 0, 0, "post_flush");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, "stall3");
        step(0, 0, 0, 0, 0, "stall3_end");
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, "stall20");
        step(0, 0, 0, 0, 0, "stall20_end");
        step(0, 0, 0, 1, 0, "halt");
        for (int i = 0; i < 4; i++) step(0, i[0], ~i[0], 1, 0, "halt_hold");
        step(0, 0, 0, 1, 1, "resume");
        step(0, 0, 0, 0, 0, "after_res");
        step(0, 0, 1, 0, 0, "br_pre_rst");
        step(1, 0, 0, 0, 0, "rst_flush");
        step(0, 0, 0, 0, 0, "reboot");
        step(0, 0, 0, 0, 0, "reboot2");
        step(0, 0, 0, 0, 0, "reboot_run");
        lu_lvl = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) lu_lvl = ~lu_lvl;
            step($urandom_range(199) == 0, lu_lvl,
                 $urandom_range(99) < 8, $urandom_range(99) < 5,
                 $urandom_range(99) < 25, "rand");
        end
        @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
